// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and lane helpers for the RAM responder.
// Byte lane 3 carries bits 31:24, the byte at offset 0 of a word.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [3:0] lane_en(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [3:0] be;
    unique case (1'b1)
      sz == SZ_BYTE: be = 4'b1000 >> off;
      sz == SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    logic [31:0] w;
    unique case (1'b1)
      sz == SZ_BYTE: w = {4{d[7:0]}};
      sz == SZ_HALF: w = {2{d[15:0]}};
      default:       w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rd_extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  off
  );
    logic [31:0] r;
    unique case (1'b1)
      sz == SZ_BYTE: r = {24'h0, w[{~off, 3'b000} +: 8]};
      sz == SZ_HALF: r = {16'h0, off[1] ? w[15:0] : w[31:16]};
      default:       r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word-indexed storage split into four byte lanes.
// Per-lane write enables; asynchronous 32-bit read port.
module mem_byte_array #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
      if (we[l]) mem[idx] <= wdata[8*l +: 8];
    end

    assign rdata[8*l +: 8] = mem[idx];
  end

endmodule

// File: rtl/ram_responder.sv
// Fixed-latency big-endian RAM slave with a four-phase MFA/MOC handshake.
// Optional MEM_ALIGN_ABORT_EN: misaligned accesses abort instead of aligning.
module ram_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MOC,
  output logic              ABORT
);

  state_e state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              moc_q, moc_d;
  logic [31:0]       dout_q, dout_d;
  logic [ADDR_W-1:0] a_q;
  logic              rw_q;
  logic [1:0]        sz_q;
  logic [31:0]       din_q;
  logic              take, fire, ok;

  logic              is_byte, is_half;
  logic [ADDR_W-1:0] aa;
  logic [3:0]        we;
  logic [31:0]       rdata;

  assign is_byte = sz_q == SZ_BYTE;
  assign is_half = sz_q == SZ_HALF;

  assign aa = is_byte ? a_q :
              is_half ? {a_q[ADDR_W-1:1], 1'b0} :
                        {a_q[ADDR_W-1:2], 2'b00};

`ifdef MEM_ALIGN_ABORT_EN
  logic abort_q, abort_d;
  logic mis;
  assign mis = (is_half & a_q[0]) |
               (!is_byte & !is_half & |a_q[1:0]);
  assign ok    = !mis;
  assign ABORT = abort_q;
`else
  assign ok    = 1'b1;
  assign ABORT = 1'b0;
`endif

  assign we = (fire && !rw_q && ok) ?
              lane_en(sz_q, aa[1:0]) : 4'b0000;

  mem_byte_array #(.AW(ADDR_W - 2)) u_mem (
    .clk   (CLK),
    .we    (we),
    .idx   (aa[ADDR_W-1:2]),
    .wdata (lane_wdata(sz_q, din_q)),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    moc_d   = moc_q;
    dout_d  = dout_q;
    take    = 1'b0;
    fire    = 1'b0;
`ifdef MEM_ALIGN_ABORT_EN
    abort_d = abort_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (MFA) begin
          take    = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          moc_d   = 1'b1;
          state_d = DONE;
          if (rw_q && ok) dout_d = rd_extract(rdata, sz_q, aa[1:0]);
`ifdef MEM_ALIGN_ABORT_EN
          abort_d = mis;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!MFA) begin
          moc_d   = 1'b0;
          state_d = IDLE;
`ifdef MEM_ALIGN_ABORT_EN
          abort_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      moc_q   <= 1'b0;
      dout_q  <= 32'h0;
      a_q     <= '0;
      rw_q    <= 1'b0;
      sz_q    <= SZ_BYTE;
      din_q   <= 32'h0;
`ifdef MEM_ALIGN_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moc_q   <= moc_d;
      dout_q  <= dout_d;
`ifdef MEM_ALIGN_ABORT_EN
      abort_q <= abort_d;
`endif
      if (take) begin
        a_q   <= ADDR;
        rw_q  <= RW;
        sz_q  <= SIZE;
        din_q <= DATA_IN;
      end
    end
  end

  assign DATA_OUT = dout_q;
  assign MOC      = moc_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed table plus handshake/reset sequences for ram_responder.
// Default build: misaligned accesses are aligned, ABORT stays 0.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mfa, rw;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        moc, abort;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ram_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .MFA      (mfa),
    .RW       (rw),
    .SIZE     (size),
    .ADDR     (addr),
    .DATA_IN  (din),
    .DATA_OUT (dout),
    .MOC      (moc),
    .ABORT    (abort)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t v[19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full handshake; inputs are scrambled after sampling.
  task automatic txn(input logic r, input logic [1:0] sz,
                     input logic [7:0] a, input logic [31:0] d,
                     input int hold, output int lat,
                     output logic [31:0] res);
    logic [31:0] snap;
    @(negedge clk);
    mfa = 1'b1; rw = r; size = sz; addr = a; din = d;
    @(posedge clk);
    #1;
    rw = ~r; size = ~sz; addr = ~a; din = ~d;
    lat = 0;
    while (!moc && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res  = dout;
    snap = dout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_moc", {31'h0, moc}, 32'h1);
      chk("hold_data", dout, snap);
    end
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk);
    #1;
    chk("moc_drop", {31'h0, moc}, 32'h0);
  endtask

  initial begin
    int lat;
    logic [31:0] res;

    v[0]  = '{1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 32'h00000000};
    v[1]  = '{1'b1, 2'b10, 8'h10, 32'h0,        32'hDEADBEEF};
    v[2]  = '{1'b1, 2'b00, 8'h11, 32'h0,        32'h000000AD};
    v[3]  = '{1'b1, 2'b01, 8'h12, 32'h0,        32'h0000BEEF};
    v[4]  = '{1'b0, 2'b00, 8'h13, 32'h12345655, 32'h0000BEEF};
    v[5]  = '{1'b1, 2'b10, 8'h10, 32'h0,        32'hDEADBE55};
    v[6]  = '{1'b1, 2'b00, 8'h10, 32'h0,        32'h000000DE};
    v[7]  = '{1'b0, 2'b10, 8'h20, 32'h11223344, 32'h000000DE};
    v[8]  = '{1'b0, 2'b01, 8'h22, 32'hFFFFCAFE, 32'h000000DE};
    v[9]  = '{1'b1, 2'b10, 8'h20, 32'h0,        32'h1122CAFE};
    v[10] = '{1'b1, 2'b10, 8'h11, 32'h0,        32'hDEADBE55};
    v[11] = '{1'b1, 2'b01, 8'h13, 32'h0,        32'h0000BE55};
    v[12] = '{1'b1, 2'b11, 8'h10, 32'h0,        32'hDEADBE55};
    v[13] = '{1'b0, 2'b00, 8'hFF, 32'h000000A5, 32'hDEADBE55};
    v[14] = '{1'b0, 2'b01, 8'hFC, 32'h0000ABCD, 32'hDEADBE55};
    v[15] = '{1'b0, 2'b00, 8'hFE, 32'h00000077, 32'hDEADBE55};
    v[16] = '{1'b1, 2'b10, 8'hFC, 32'h0,        32'hABCD77A5};
    v[17] = '{1'b1, 2'b00, 8'hFF, 32'h0,        32'h000000A5};
    v[18] = '{1'b1, 2'b01, 8'h20, 32'h0,        32'h00001122};

    rst_n = 1'b0; mfa = 1'b0; rw = 1'b0;
    size = 2'b00; addr = 8'h0; din = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_moc", {31'h0, moc}, 32'h0);
    chk("rst_abort", {31'h0, abort}, 32'h0);
    chk("rst_data", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      txn(v[i].rw, v[i].sz, v[i].a, v[i].d, 0, lat, res);
      chk($sformatf("v%0d_lat", i), lat, 32'd2);
      chk($sformatf("v%0d_data", i), res, v[i].exp);
      chk($sformatf("v%0d_abort", i), {31'h0, abort}, 32'h0);
    end

    txn(1'b1, 2'b10, 8'h10, 32'h0, 10, lat, res);
    chk("hold_lat", lat, 32'd2);
    chk("hold_rd", res, 32'hDEADBE55);
    txn(1'b1, 2'b00, 8'h12, 32'h0, 0, lat, res);
    chk("b2b_lat", lat, 32'd2);
    chk("b2b_rd", res, 32'h000000BE);

    // MFA released while the access is still pending
    @(negedge clk);
    mfa = 1'b1; rw = 1'b1; size = 2'b10; addr = 8'h20;
    @(posedge clk);
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk);
    #1;
    chk("early_wait", {31'h0, moc}, 32'h0);
    @(posedge clk);
    #1;
    chk("early_moc", {31'h0, moc}, 32'h1);
    chk("early_rd", dout, 32'h1122CAFE);
    @(posedge clk);
    #1;
    chk("early_drop", {31'h0, moc}, 32'h0);

    // reset during WAIT of a word write
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; size = 2'b10;
    addr = 8'h20; din = 32'h12345678;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_moc", {31'h0, moc}, 32'h0);
    chk("rstw_data", dout, 32'h0);
    @(negedge clk);
    mfa = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // reset while MOC is high
    @(negedge clk);
    mfa = 1'b1; rw = 1'b1; size = 2'b10; addr = 8'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("rstd_pre", {31'h0, moc}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstd_moc", {31'h0, moc}, 32'h0);
    chk("rstd_data", dout, 32'h0);
    @(negedge clk);
    mfa = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    txn(1'b1, 2'b10, 8'h20, 32'h0, 0, lat, res);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_20", res, 32'h1122CAFE);
    txn(1'b1, 2'b10, 8'h10, 32'h0, 0, lat, res);
    chk("post_rst_10", res, 32'hDEADBE55);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter: ADDR_W, 8, byte-address width; memory depth is 2**ADDR_W bytes.
REQ-002 Parameter: LATENCY, 2, cycles from MFA sample to MOC assertion; legal range 1..15.
REQ-003 Port: CLK  in  1  single clock; all state changes on rising edge.
REQ-004 Port: RESET_N  in  1  asynchronous, active-low reset.
REQ-005 Port: MFA  in  1  memory function activate; request from the multiple-transfer/load-store controller.
REQ-006 Port: RW  in  1  1 = read, 0 = write.
REQ-007 Port: SIZE  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 Port: ADDR  in  ADDR_W  byte address.
REQ-009 Port: DATA_IN  in  32  write data, right-justified for byte/halfword.
REQ-010 Port: DATA_OUT  out  32  read data, registered.
REQ-011 Port: MOC  out  1  memory operation complete, registered.
REQ-012 Port: ABORT  out  1  alignment abort, registered.

Function
REQ-013 FSM states IDLE, WAIT, DONE; state register, MOC, ABORT, DATA_OUT all registered.
REQ-014 IDLE with MFA=1 at an edge: latch ADDR, RW, SIZE, DATA_IN; load counter with LATENCY-1; go to WAIT.
REQ-015 WAIT: counter decrements each edge; request inputs ignored (latched copy used).
REQ-016 WAIT with counter=0: perform access, set MOC=1, go to DONE on same edge; MOC first high LATENCY cycles after the MFA sampling edge.
REQ-017 DONE: MOC held 1 and DATA_OUT held stable while MFA=1.
REQ-018 DONE with MFA=0 at an edge: MOC=0, ABORT=0, go to IDLE; new request accepted no earlier than the following edge (four-phase handshake).
REQ-019 MFA dropped during WAIT: transaction still completes; MOC high for exactly one cycle, then IDLE.
REQ-020 Byte order big-endian: word at A occupies bytes A..A+3, MSB at A.
REQ-021 Read byte: DATA_OUT = zero-extended byte; halfword: zero-extended; word: full 32 bits.
REQ-022 Write: only the addressed 1/2/4 bytes updated from DATA_IN low bits; DATA_OUT unchanged on writes.
REQ-023 Alignment (macro absent): ADDR[0] forced 0 for halfword, ADDR[1:0] forced 0 for word; no access crosses the top of memory.
REQ-024 Back-to-back transactions (MFA reasserted one cycle after MOC falls) each take full LATENCY.

Reset
REQ-025 RESET_N=0 asynchronously: state IDLE, MOC=0, ABORT=0, DATA_OUT=0, counter=0.
REQ-026 Reset during WAIT or DONE discards the pending access; a pending write never reaches memory.
REQ-027 Memory contents are not cleared by reset.

Configuration
REQ-028 Macro MEM_ALIGN_ABORT_EN defined: misaligned halfword/word access performs no memory read/write, leaves DATA_OUT unchanged, and asserts MOC and ABORT together in DONE with the normal latency.
REQ-029 Macro MEM_ALIGN_ABORT_EN undefined: REQ-023 applies and ABORT is constant 0.

Structure
REQ-030 Package mem_pkg holds SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and default LATENCY.
REQ-031 Sub-module mem_byte_array holds storage as four byte lanes with per-lane write enables and a 32-bit read port; ram_responder owns FSM, latching, lane steering and extension.

Verification
REQ-032 Reset, write word 0xDEADBEEF at 0x10, read word 0x10 -> DATA_OUT=0xDEADBEEF; MOC rises exactly 2 edges after MFA sampled.
REQ-033 After REQ-032, read byte 0x11 -> 0x000000AD; read halfword 0x12 -> 0x0000BEEF.
REQ-034 Write byte 0x55 at 0x13, read word 0x10 -> 0xDEADBE55; other bytes untouched.
REQ-035 Hold MFA=1 for 10 cycles after MOC -> MOC and DATA_OUT stable; drop MFA -> MOC=0 next edge, next request accepted after.
REQ-036 Assert RESET_N=0 mid-WAIT of word write 0x12345678 at 0x20 -> MOC=0 immediately; later read 0x20 returns pre-reset contents.
REQ-037 Word read at 0x11: without MEM_ALIGN_ABORT_EN -> data of 0x10, ABORT=0; with macro -> MOC=1, ABORT=1, DATA_OUT unchanged.
